ofdm_symbol_streamer: RTL
=========================

// Module: ofdm_symbol_streamer
// PURPOSE
//  Downstream neighbour of the receiver time-sync / CP-removal stage. Once that stage flags its
//  output buffer full, this block walks the buffer read pointer over NUM_SYM x SYM_LEN CP-free
//  samples. It streams them to the FFT over a valid/ready byte stream, with per-symbol framing
//  and a symbol-type tag. At end of burst it pulses burst_done, which re-arms the upstream stage.
// PARAMETERS
//  SYM_LEN   64  samples per OFDM symbol (FFT points); power of two
//  NUM_SYM   12  symbols per burst (first NUM_CE are channel-estimation, rest data)
//  NUM_CE    4   channel-estimation symbols at the head of the burst
//  ADDR_W    10  rd_ptr width; must satisfy NUM_SYM*SYM_LEN <= 2**ADDR_W
// PORTS
//  clk         in   1       system clock, all logic on posedge
//  rst_n       in   1       asynchronous active-low reset
//  buf_full    in   1       upstream output buffer holds a complete CP-stripped burst (level)
//  rd_ptr      out  ADDR_W  upstream buffer read address (registered)
//  rd_data     in   8       upstream buffer data; valid exactly 1 cycle after rd_ptr changes
//  m_tdata     out  8       sample to FFT
//  m_tvalid    out  1       m_tdata valid
//  m_tready    in   1       FFT accepts when m_tvalid & m_tready
//  m_tlast     out  1       high on the last sample (index SYM_LEN-1) of every symbol
//  m_tuser     out  1       1 = channel-estimation symbol (sym_idx < NUM_CE), 0 = data symbol
//  burst_done  out  1       one-cycle pulse after the final sample is accepted; drives tx_done
//  busy        out  1       high in any state other than IDLE
// BEHAVIOUR
//  Reset: rd_ptr=0, m_tvalid=0, m_tdata=0, m_tlast=0, m_tuser=0, burst_done=0, busy=0.
//   Skid buffer emptied; FSM=IDLE; all counters 0. Reset mid-burst abandons the burst silently.
//  FSM:
//   IDLE   -> STREAM when buf_full=1; clears rd_ptr, sample and symbol counters.
//   STREAM -> issues one read per cycle while credit allows. Credit rule:
//             skid occupancy + reads in flight <= 2.
//             rd_data is captured into the skid one cycle after issue.
//             After the last address (NUM_SYM*SYM_LEN-1) is issued -> DRAIN.
//   DRAIN  -> no further reads. When the final sample handshakes -> DONE, and burst_done=1
//             for exactly that next cycle.
//   DONE   -> waits for buf_full=0, so a stale full never restarts the block -> IDLE.
//             If buf_full is still 1 after 2**ADDR_W cycles, stay in DONE (no re-stream).
//  Latency: buf_full rises at edge E. FSM enters STREAM at E+1, first rd_ptr=0 at E+1,
//   data captured at E+2, m_tvalid=1 from E+2.
//  Stream rules:
//   - m_tdata/m_tlast/m_tuser are held stable while m_tvalid & !m_tready (AXI-style).
//   - m_tvalid never drops until the sample is accepted.
//   - Throughput with m_tready tied high: 1 sample/cycle, no bubbles.
//  Counters:
//   - samp_cnt is log2(SYM_LEN) bits and wraps to 0 after SYM_LEN-1.
//   - sym_cnt increments on each wrap.
//   - Framing counters advance on the output handshake, not on read issue.
//   - tlast = (samp_cnt==SYM_LEN-1); tuser = (sym_cnt<NUM_CE).
//  Boundary cases:
//   - buf_full falling mid-STREAM/DRAIN is ignored; the burst completes.
//   - m_tready low for any duration loses and duplicates nothing.
//   - rd_ptr never exceeds NUM_SYM*SYM_LEN-1.
// STRUCTURE
//  Shared package (ofdm_rx_pkg): SYM_LEN, NUM_SYM, NUM_CE, ADDR_W defaults;
//   FSM state encoding {IDLE, STREAM, DRAIN, DONE}; typedef for the 8-bit sample.
//  One sub-module: ofdm_skid_buf. 2-entry, 10-bit wide FIFO holding {tlast,tuser,data};
//   provides occupancy for credit checking. The top level holds the FSM, address counter and
//   framing counters.
// TESTING
//  1. m_tready=1, buffer preloaded with addr[7:0] -> 768 beats, data 0x00..0xFF repeating,
//     tlast at beats 63,127,..,767, tuser=1 for beats 0..255, burst_done one pulse after beat 767.
//  2. m_tready toggling 1-0-1-0 -> identical 768-byte sequence, tdata stable while stalled.
//     rd_ptr never more than 2 ahead of accepted beats.
//  3. m_tready=0 for 100 cycles after the first beat -> m_tvalid held, tdata=0x00 held.
//     Then 767 further beats in order.
//  4. buf_full held high 20 cycles after burst_done -> no second burst; busy=1 until buf_full=0;
//     re-assert -> new burst starts at rd_ptr=0.
//  5. rst_n asserted at beat 300 -> all outputs zero asynchronously.
//     Next buf_full -> stream restarts at address 0 with tuser=1.
//  6. buf_full deasserted at beat 10 -> burst still completes all 768 beats with one burst_done.

Source files
------------

// File: rtl/ofdm_rx_pkg.sv
// Shared definitions for the receiver back end: burst geometry defaults, streamer FSM states,
// and the sample / skid-entry types.
package ofdm_rx_pkg;

    localparam int DEF_SYM_LEN = 64;
    localparam int DEF_NUM_SYM = 12;
    localparam int DEF_NUM_CE  = 4;
    localparam int DEF_ADDR_W  = 10;
    localparam int SKID_W      = 10;

    typedef logic [7:0] sample_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } stream_state_t;

    typedef struct packed {
        logic    tlast;
        logic    tuser;
        sample_t data;
    } skid_word_t;

endpackage

// File: rtl/ofdm_symbol_streamer_if.sv
// Valid/ready byte stream towards the FFT, carrying symbol framing (tlast) and CE tag (tuser).
interface ofdm_symbol_streamer_if;
    import ofdm_rx_pkg::*;

    sample_t tdata;
    logic    tvalid;
    logic    tready;
    logic    tlast;
    logic    tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);

endinterface

// File: rtl/ofdm_skid_buf.sv
// Two-entry FIFO between the buffer read port and the output stream; exposes its occupancy
// so the read issuer never has more samples outstanding than it can hold.
module ofdm_skid_buf
    import ofdm_rx_pkg::*;
#(
    parameter int W = SKID_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic [1:0]   occ
);

    logic [W-1:0] mem [2];
    logic         wr_sel;
    logic         rd_sel;

    // Push is only ever issued with credit in hand, so no full check is needed here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_sel] <= din;
                wr_sel      <= ~wr_sel;
            end
            if (pop) begin
                rd_sel <= ~rd_sel;
            end
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

    assign dout  = mem[rd_sel];
    assign empty = (occ == 2'd0);

endmodule

// File: rtl/ofdm_symbol_streamer.sv
// Walks the upstream CP-free burst buffer once per buf_full and streams it to the FFT with
// per-symbol tlast and a channel-estimation tuser tag; pulses burst_done at the end.
module ofdm_symbol_streamer
    import ofdm_rx_pkg::*;
#(
    parameter int SYM_LEN = DEF_SYM_LEN,
    parameter int NUM_SYM = DEF_NUM_SYM,
    parameter int NUM_CE  = DEF_NUM_CE,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  buf_full,
    output logic [ADDR_W-1:0]     rd_ptr,
    input  sample_t               rd_data,
    ofdm_symbol_streamer_if.master m_axis,
    output logic                  burst_done,
    output logic                  busy
);

    localparam int SAMP_W = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
    localparam int SYM_W  = (NUM_SYM > 1) ? $clog2(NUM_SYM) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_SYM * SYM_LEN - 1);
    localparam logic [ADDR_W-1:0] CE_END    = ADDR_W'(NUM_CE * SYM_LEN);

    stream_state_t     state;
    stream_state_t     state_next;
    logic [ADDR_W-1:0] rd_ptr_next;
    logic              rd_pend;
    logic              rd_pend_next;
    logic              burst_done_next;
    logic [SAMP_W-1:0] samp_cnt;
    logic [SYM_W-1:0]  sym_cnt;

    skid_word_t        skid_in;
    skid_word_t        skid_out;
    logic              skid_empty;
    logic [1:0]        skid_occ;
    logic [1:0]        occ_after;
    logic              handshake;
    logic              can_issue;
    logic              final_beat;

    // rd_pend marks that rd_ptr holds an address whose data is captured at the next edge.
    // Tags are derived from that address; they equal the handshake-side framing counters.
    assign skid_in.data  = rd_data;
    assign skid_in.tlast = (rd_ptr[SAMP_W-1:0] == SAMP_W'(SYM_LEN - 1));
    assign skid_in.tuser = (rd_ptr < CE_END);

    ofdm_skid_buf #(.W(SKID_W)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rd_pend),
        .din   (skid_in),
        .pop   (handshake),
        .dout  (skid_out),
        .empty (skid_empty),
        .occ   (skid_occ)
    );

    assign handshake  = !skid_empty && m_axis.tready;
    assign occ_after  = skid_occ + {1'b0, rd_pend} - {1'b0, handshake};
    assign can_issue  = (occ_after <= 2'd1);
    assign final_beat = handshake
                        && (samp_cnt == SAMP_W'(SYM_LEN - 1))
                        && (sym_cnt == SYM_W'(NUM_SYM - 1));

    assign m_axis.tvalid = !skid_empty;
    assign m_axis.tdata  = skid_out.data;
    assign m_axis.tlast  = skid_out.tlast;
    assign m_axis.tuser  = skid_out.tuser;
    assign busy          = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rd_ptr     <= '0;
            rd_pend    <= 1'b0;
            burst_done <= 1'b0;
        end else begin
            state      <= state_next;
            rd_ptr     <= rd_ptr_next;
            rd_pend    <= rd_pend_next;
            burst_done <= burst_done_next;
        end
    end

    // DONE only leaves on buf_full low, so a stale full level can never restart the burst.
    always_comb begin
        state_next      = state;
        rd_ptr_next     = rd_ptr;
        rd_pend_next    = 1'b0;
        burst_done_next = 1'b0;
        case (state)
            IDLE: begin
                if (buf_full) begin
                    state_next   = STREAM;
                    rd_ptr_next  = '0;
                    rd_pend_next = 1'b1;
                end
            end
            STREAM: begin
                if (can_issue) begin
                    rd_ptr_next  = rd_ptr + 1'b1;
                    rd_pend_next = 1'b1;
                    if (rd_ptr == LAST_ADDR - 1'b1) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (final_beat) begin
                    state_next      = DONE;
                    burst_done_next = 1'b1;
                end
            end
            DONE: begin
                if (!buf_full) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_cnt <= '0;
            sym_cnt  <= '0;
        end else if (state == IDLE) begin
            samp_cnt <= '0;
            sym_cnt  <= '0;
        end else if (handshake) begin
            samp_cnt <= samp_cnt + 1'b1;
            if (samp_cnt == SAMP_W'(SYM_LEN - 1)) begin
                sym_cnt <= (sym_cnt == SYM_W'(NUM_SYM - 1)) ? '0 : sym_cnt + 1'b1;
            end
        end
    end

endmodule
